// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the asynchronous FIFO.
//   ADDRSIZE  : default FIFO address width (depth = 2**ADDRSIZE)
//   DATASIZE  : default data word width
//   PTR_W     : width of the gray/binary pointers (ADDRSIZE+1)
//   skid_cnt_t: occupancy of the 2-entry skid buffer (0..2)
//   gray2bin  : gray-to-binary conversion over PTR_W bits. The write-side
//               level logic and the read-side empty/level logic both use it.
// The pointer width of gray2bin follows the package ADDRSIZE, so modules that
// call it keep their ADDRSIZE parameter at the package default.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int ADDRSIZE = 4;
  localparam int DATASIZE = 8;
  localparam int PTR_W    = ADDRSIZE + 1;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] skid_cnt_t;

  // Binary bit i is the XOR of gray bits [PTR_W-1:i] (prefix XOR from the MSB).
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
    logic [PTR_W-1:0] bin;
    bin[PTR_W-1] = gray[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry valid/ready buffer between the upstream stream and the FIFO write
// port. The head entry is always the oldest word.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : upstream word valid
//   in_data    : upstream word
//   in_ready   : buffer can take a word (registered count only)
//   out_valid  : head entry holds a word
//   out_data   : head entry
//   out_ready  : downstream takes the head entry this cycle
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer keeps valid and data stable until that edge; ready
// never depends combinationally on valid. Here in_ready and out_valid are
// decoded purely from the registered count, so neither side sees a
// combinational path from the other side's handshake.
// -----------------------------------------------------------------------------
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATASIZE = fifo_pkg::DATASIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DATASIZE-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATASIZE-1:0] out_data,
  input  logic                out_ready
);

  logic [DATASIZE-1:0] mem [SKID_DEPTH];
  logic                head;
  logic                tail;
  skid_cnt_t           count;
  logic                push;
  logic                pop;

  assign in_ready  = (count != skid_cnt_t'(SKID_DEPTH));
  assign out_valid = (count != skid_cnt_t'(0));
  assign out_data  = mem[head];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // First free slot is head+count (mod 2). At count=2 no push happens, so
  // only count[0] matters.
  assign tail = head ^ count[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= in_data;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + skid_cnt_t'(1);
        2'b01:   count <= count - skid_cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_wr_front.sv
// -----------------------------------------------------------------------------
// fifo_wr_front
// Write-domain front end of the asynchronous FIFO. Converts an upstream
// valid/ready stream into write enable/data for the pointer block through a
// 2-entry skid buffer, and reports the write-side fill level and an
// almost-full flag.
//
// Ports:
//   i_wr_clk, i_wr_rst : write clock, asynchronous active-high reset
//   i_s_valid/i_s_data : upstream word
//   o_s_ready          : front end can accept a word
//   o_wr_en/o_wr_data  : write request and word to the pointer block/memory
//   i_full             : registered full flag from the pointer block
//   i_wr_ptr           : gray write pointer
//   i_rd_ptr_clx       : gray read pointer synchronised into this domain
//   i_afull_thresh     : almost-full threshold in words
//   o_level            : registered fill level (words in the FIFO memory)
//   o_afull            : registered almost-full flag
//
// A word is committed on the edge where o_wr_en=1 and i_full=0; the pointer
// block gates its increment with the same full flag, so both agree on every
// write. Words still inside the skid buffer are not part of o_level.
// -----------------------------------------------------------------------------
module fifo_wr_front
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = fifo_pkg::ADDRSIZE,
  parameter int DATASIZE = fifo_pkg::DATASIZE
) (
  input  logic                i_wr_clk,
  input  logic                i_wr_rst,
  input  logic                i_s_valid,
  input  logic [DATASIZE-1:0] i_s_data,
  output logic                o_s_ready,
  output logic                o_wr_en,
  output logic [DATASIZE-1:0] o_wr_data,
  input  logic                i_full,
  input  logic [ADDRSIZE:0]   i_wr_ptr,
  input  logic [ADDRSIZE:0]   i_rd_ptr_clx,
  input  logic [ADDRSIZE:0]   i_afull_thresh,
  output logic [ADDRSIZE:0]   o_level,
  output logic                o_afull
);

  logic [ADDRSIZE:0] wr_bin;
  logic [ADDRSIZE:0] rd_bin;
  logic [ADDRSIZE:0] level_next;
  logic              afull_next;

  fifo_skid_buf #(
    .DATASIZE (DATASIZE)
  ) u_skid (
    .clk       (i_wr_clk),
    .rst       (i_wr_rst),
    .in_valid  (i_s_valid),
    .in_data   (i_s_data),
    .in_ready  (o_s_ready),
    .out_valid (o_wr_en),
    .out_data  (o_wr_data),
    .out_ready (~i_full)
  );

  assign wr_bin = gray2bin(i_wr_ptr);
  assign rd_bin = gray2bin(i_rd_ptr_clx);

  // Pointers carry one extra wrap bit, so the difference taken modulo
  // 2**(ADDRSIZE+1) is the occupancy even across the MSB toggle.
  assign level_next = wr_bin - rd_bin;
  assign afull_next = (level_next >= i_afull_thresh);

  always_ff @(posedge i_wr_clk or posedge i_wr_rst) begin
    if (i_wr_rst) begin
      o_level <= '0;
      o_afull <= 1'b0;
    end else begin
      o_level <= level_next;
      o_afull <= afull_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_front.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_front
// Directed steps followed by a randomized phase. The reference model keeps
// the skid contents as a queue of words (exp_q), the upstream backlog as a
// queue (src_q), and the pointer block as plain binary write/read counts.
// Level is the arithmetic difference of those counts.
// -----------------------------------------------------------------------------
module tb_fifo_wr_front;
  import fifo_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] afull_thresh;
  logic [PW-1:0] level;
  logic          afull;

  fifo_wr_front #(.ADDRSIZE(AW), .DATASIZE(DW)) dut (
    .i_wr_clk       (clk),
    .i_wr_rst       (rst),
    .i_s_valid      (s_valid),
    .i_s_data       (s_data),
    .o_s_ready      (s_ready),
    .o_wr_en        (wr_en),
    .o_wr_data      (wr_data),
    .i_full         (full),
    .i_wr_ptr       (wr_ptr),
    .i_rd_ptr_clx   (rd_ptr),
    .i_afull_thresh (afull_thresh),
    .o_level        (level),
    .o_afull        (afull)
  );

  // ---------------- model state / scoreboard ----------------
  logic [DW-1:0] exp_q[$];   // words inside the front end, oldest first
  logic [DW-1:0] src_q[$];   // words waiting upstream
  int            wbin;       // committed words (binary write pointer)
  int            rbin;       // binary read pointer seen in write domain
  int            thresh;
  bit            valid_en;
  bit            full_ctl;
  logic [PW-1:0] level_exp;
  logic          afull_exp;

  int tests = 0;
  int fails = 0;

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = b[PW-1:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("ready", 32'(s_ready), 32'(exp_q.size() < 2));
    check("wr_en", 32'(wr_en), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("wr_data", 32'(wr_data), 32'(exp_q[0]));
    check("level", 32'(level), 32'(level_exp));
    check("afull", 32'(afull), 32'(afull_exp));
  endtask

  // ---------------- driver: one clock, called at a negedge ----------------
  task automatic step();
    bit            push;
    bit            pop;
    int            diff;
    logic [PW-1:0] lvl;
    s_valid      = valid_en && (src_q.size() > 0);
    s_data       = (src_q.size() > 0) ? src_q[0] : DW'($urandom);
    full         = full_ctl;
    wr_ptr       = to_gray(wbin);
    rd_ptr       = to_gray(rbin);
    afull_thresh = thresh[PW-1:0];
    push = s_valid && (exp_q.size() < 2);
    pop  = (exp_q.size() > 0) && !full_ctl;
    diff = wbin - rbin;
    lvl  = diff[PW-1:0];
    @(posedge clk);
    if (pop) begin
      void'(exp_q.pop_front());
      wbin++;
    end
    if (push) exp_q.push_back(src_q.pop_front());
    level_exp = lvl;
    afull_exp = (int'(lvl) >= thresh);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; full = 1'b0;
    wr_ptr = '0; rd_ptr = '0; afull_thresh = '0;
    wbin = 0; rbin = 0; thresh = 12;
    valid_en = 1'b0; full_ctl = 1'b0;
    level_exp = '0; afull_exp = 1'b0;

    // Reset values while reset is held
    #1;
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_afull", 32'(afull), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: idle first clock after release
    step();
    check("t1_data", 32'(wr_data), 32'd0);

    // 2: stream 0x00..0x0F, read pointer at 0, threshold 12
    for (int i = 0; i < DEPTH; i++) src_q.push_back(DW'(i));
    valid_en = 1'b1;
    for (int k = 0; k < 40 && wbin < DEPTH; k++) step();
    full_ctl = 1'b1;
    step();
    check("t2_level16", 32'(level), 32'(DEPTH));
    check("t2_afull", 32'(afull), 32'd1);

    // 4a: everything read, both pointers at binary 16 (gray 0x18)
    rbin = DEPTH;
    full_ctl = 1'b0;
    step();
    step();
    check("t4_level0", 32'(level), 32'd0);
    check("t4_afull0", 32'(afull), 32'd0);

    // 3: full held for 5 cycles while offering A1,A2,A3
    full_ctl = 1'b1;
    src_q.push_back(8'hA1); src_q.push_back(8'hA2); src_q.push_back(8'hA3);
    repeat (5) step();
    check("t3_ready0", 32'(s_ready), 32'd0);
    check("t3_hold", 32'(wr_data), 32'hA1);
    check("t3_wr_en", 32'(wr_en), 32'd1);
    full_ctl = 1'b0;
    for (int k = 0; k < 10 && (exp_q.size() > 0 || src_q.size() > 0); k++) step();
    step();
    // 4b: three more words past the wrap point
    check("t4_level3", 32'(level), 32'd3);

    // 6b: threshold 16 with level 15
    rbin = wbin - 15;
    thresh = 16;
    step();
    step();
    check("t6_level15", 32'(level), 32'd15);
    check("t6_afull16", 32'(afull), 32'd0);
    thresh = 15;
    step();
    check("t6_afull15", 32'(afull), 32'd1);

    // Randomized phase
    rbin = wbin;
    for (int n = 0; n < 400; n++) begin
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1) src_q.push_back(DW'($urandom));
      if (rbin < wbin && $urandom_range(0, 2) == 0) rbin++;
      if ($urandom_range(0, 15) == 0) thresh = $urandom_range(0, DEPTH);
      valid_en = ($urandom_range(0, 3) != 0);
      full_ctl = ((wbin - rbin) >= DEPTH) || ($urandom_range(0, 3) == 0);
      step();
    end

    // 5: asynchronous reset with both entries occupied
    full_ctl = 1'b1;
    valid_en = 1'b1;
    src_q.delete();
    src_q.push_back(8'h5A); src_q.push_back(8'hC3);
    repeat (3) step();
    check("t5_full2", 32'(s_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t5_ready", 32'(s_ready), 32'd1);
    check("t5_wr_en", 32'(wr_en), 32'd0);
    check("t5_data", 32'(wr_data), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_afull", 32'(afull), 32'd0);
    exp_q.delete();
    src_q.delete();
    wbin = 0; rbin = 0;
    level_exp = '0; afull_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 6a: threshold 0 forces almost-full after the first clock
    thresh = 0;
    valid_en = 1'b0;
    full_ctl = 1'b0;
    step();
    check("t6_afull_thr0", 32'(afull), 32'd1);
    check("t5_no_stale", 32'(wr_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_front.md
Name: fifo_wr_front

Overview:
- Write-domain front end of the N-bit asynchronous FIFO; sits directly upstream of the write pointer/full-flag block.
- Converts an upstream valid/ready stream into write-enable and write-data for the FIFO memory through a 2-entry skid buffer.
- Respects the registered full flag and reports fill level plus a programmable almost-full flag.
- Fill level is derived from the gray write pointer and the read pointer already synchronised into the write domain.

Parameters:
- ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE.
- DATASIZE, 8, data word width.

Ports:
- i_wr_clk  in  1  write-domain clock.
- i_wr_rst  in  1  asynchronous, active-high reset.
- i_s_valid  in  1  upstream word valid.
- i_s_data  in  DATASIZE  upstream word.
- o_s_ready  out  1  front end can accept a word.
- o_wr_en  out  1  write request to the pointer block (drives its i_wr_en).
- o_wr_data  out  DATASIZE  word for the memory at the current write address.
- i_full  in  1  registered full flag from the pointer block.
- i_wr_ptr  in  ADDRSIZE+1  gray write pointer from the pointer block.
- i_rd_ptr_clx  in  ADDRSIZE+1  gray read pointer, synchronised into the write domain.
- i_afull_thresh  in  ADDRSIZE+1  almost-full threshold, in words.
- o_level  out  ADDRSIZE+1  registered fill level (write-side view).
- o_afull  out  1  registered almost-full flag.

Behaviour:
- Reset (i_wr_rst=1, asynchronous): skid count=0, both entries cleared; o_s_ready=1, o_wr_en=0, o_wr_data=0, o_level=0, o_afull=0. Reset asserted mid-transfer drops all buffered words.
- Skid buffer holds 2 entries; count ranges 0..2; head is the oldest entry.
  - push = i_s_valid & o_s_ready
  - pop = o_wr_en & !i_full
  - o_s_ready = (count != 2), decoded from registered count only; no combinational path from i_full.
  - o_wr_en = (count != 0); o_wr_data = head entry, valid whenever o_wr_en=1.
  - A word is committed on the rising edge where pop=1. The pointer block gates with the same full flag, so a write is counted exactly when pop=1.
- Push and pop in the same cycle: count unchanged, head advances, new word appended. Sustained 1 word/clock at count=1.
- count=2: no push. A pop that cycle leaves count=1 and ready rises next cycle. Worst-case accept bubble is 1 cycle.
- i_full=1: no pop, data held stable, o_wr_en stays 1. Upstream stalls only once both entries are occupied.
- Order is preserved; words are never dropped or duplicated.
- Level, registered every cycle:
  - o_level <= gray2bin(i_wr_ptr) - gray2bin(i_rd_ptr_clx), modulo 2**(ADDRSIZE+1).
  - Range 0..2**ADDRSIZE. Pessimistic: lags reads by the synchroniser delay.
- o_afull <= (level_next >= i_afull_thresh), evaluated on the same level_next. Threshold 0 forces o_afull=1 after the first clock out of reset.
- Pointer wrap (MSB toggle) must not disturb o_level; the modulo subtraction handles it.
- Words in the skid buffer are not counted in o_level.

Decomposition:
- Package fifo_pkg:
  - ADDRSIZE/DATASIZE defaults.
  - function gray2bin (XOR-prefix over ADDRSIZE+1 bits), shared with the read-side empty/level logic.
- Sub-module fifo_skid_buf (2-entry valid/ready buffer with push/pop and count):
  - Top instantiates it and adds the level/almost-full registers.

Test Plan:
1. Reset release, i_s_valid=0 -> o_s_ready=1, o_wr_en=0, o_level=0, o_afull=0 on the first clock.
2. Continuous valid, data 0x00..0x0F, i_full=0, read pointer fixed at 0 -> one word committed per clock in order. o_level climbs 1..16 with i_wr_ptr. o_afull rises the cycle level reaches threshold 12.
3. i_full=1 for 5 cycles while pushing 0xA1,0xA2,0xA3 -> accepts 0xA1,0xA2; o_s_ready=0 with 0xA3 held upstream; o_wr_data=0xA1 stable. On release, writes A1,A2,A3 back-to-back with one ready bubble.
4. Wrap: write 16 words, then pointers both at binary 16 (gray 0x18) -> o_level=0. Write 3 more -> o_level=3, no glitch across the MSB toggle.
5. Assert i_wr_rst asynchronously with count=2 -> outputs reach reset values before the next edge. After release, no stale word is presented.
6. i_afull_thresh=0 -> o_afull=1 from the first post-reset clock. Threshold 16 with level 15 -> o_afull=0.
